// File: rtl/sync_fifo_v2_if.sv
// Handshake bundle for sync_fifo_v2.
//   master : request side (drives i_* and reads back o_*)
//   slave  : the FIFO (samples i_* and drives o_*)
// Signals: write port (i_wren, i_wrdata), read port (i_rden, o_rddata,
// o_rdvalid), status (o_full, o_empty, o_alm_full, o_alm_empty, o_count).
// With SYNC_FIFO_V2_ERR_EN defined the bundle also carries i_clr_err,
// o_overflow and o_underflow.
interface sync_fifo_v2_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic [DATA_W-1:0] o_rddata;
  logic              o_rdvalid;
  logic              o_full;
  logic              o_empty;
  logic              o_alm_full;
  logic              o_alm_empty;
  logic [CW-1:0]     o_count;
`ifdef SYNC_FIFO_V2_ERR_EN
  logic              i_clr_err;
  logic              o_overflow;
  logic              o_underflow;

  modport master (output i_wren, i_wrdata, i_rden, i_clr_err,
                  input  o_rddata, o_rdvalid, o_full, o_empty, o_alm_full,
                         o_alm_empty, o_count, o_overflow, o_underflow);
  modport slave  (input  i_wren, i_wrdata, i_rden, i_clr_err,
                  output o_rddata, o_rdvalid, o_full, o_empty, o_alm_full,
                         o_alm_empty, o_count, o_overflow, o_underflow);
`else
  modport master (output i_wren, i_wrdata, i_rden,
                  input  o_rddata, o_rdvalid, o_full, o_empty, o_alm_full,
                         o_alm_empty, o_count);
  modport slave  (input  i_wren, i_wrdata, i_rden,
                  output o_rddata, o_rdvalid, o_full, o_empty, o_alm_full,
                         o_alm_empty, o_count);
`endif
endinterface

// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO, any DEPTH >= 2 (power of two not required).
// Ports: clk (rising edge), rst (async, active-high), bus (sync_fifo_v2_if
// slave modport: write/read handshake, data, count and status flags).
// FWFT=0 : accepted read registers the head word into o_rddata; o_rdvalid
//          pulses the following cycle.
// FWFT=1 : o_rddata shows the head word combinationally, o_rdvalid=!empty.
// Optional macro SYNC_FIFO_V2_ERR_EN adds sticky o_overflow/o_underflow
// flags cleared by i_clr_err.
module sync_fifo_v2 #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int UPP_TH = DEPTH - 2,
  parameter int LOW_TH = 2,
  parameter int FWFT   = 0
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_v2_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wrptr_q, wrptr_d, rdptr_q, rdptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              full, empty, wr_ok, rd_ok;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    // A full FIFO rejects writes even when a read frees a slot this cycle.
    wr_ok   = bus.i_wren && !full;
    rd_ok   = bus.i_rden && !empty;
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    // Explicit wrap compare keeps non-power-of-two depths correct.
    if (wr_ok) wrptr_d = (wrptr_q == PW'(DEPTH - 1)) ? '0 : wrptr_q + 1'b1;
    if (rd_ok) rdptr_d = (rdptr_q == PW'(DEPTH - 1)) ? '0 : rdptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wrptr_q] <= bus.i_wrdata;
  end

  // Status flags come straight off the registered count.
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_count     = count_q;
  assign bus.o_alm_full  = (count_q >= CW'(UPP_TH));
  assign bus.o_alm_empty = (count_q <= CW'(LOW_TH));

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.o_rddata  = mem[rdptr_q];
      assign bus.o_rdvalid = !empty;
    end else begin : g_reg
      logic [DATA_W-1:0] rddata_q, rddata_d;
      logic              rdvalid_q, rdvalid_d;

      always_comb begin
        rddata_d  = rddata_q;
        rdvalid_d = rd_ok;
        if (rd_ok) rddata_d = mem[rdptr_q];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rddata_q  <= '0;
          rdvalid_q <= 1'b0;
        end else begin
          rddata_q  <= rddata_d;
          rdvalid_q <= rdvalid_d;
        end
      end

      assign bus.o_rddata  = rddata_q;
      assign bus.o_rdvalid = rdvalid_q;
    end
  endgenerate

`ifdef SYNC_FIFO_V2_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Set is applied after clear so a simultaneous error wins.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.i_clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.i_wren && full)  ovf_d = 1'b1;
    if (bus.i_rden && empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;
`endif
endmodule

// File: tb/tb_sync_fifo_v2.sv
module tb_sync_fifo_v2;
  localparam int DW = 16, DP = 6, UT = 4, LT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_fifo_v2_if #(.DATA_W(DW), .DEPTH(DP)) f0 ();
  sync_fifo_v2_if #(.DATA_W(DW), .DEPTH(DP)) f1 ();

  sync_fifo_v2 #(.DATA_W(DW), .DEPTH(DP), .UPP_TH(UT), .LOW_TH(LT), .FWFT(0))
    u_reg (.clk(clk), .rst(rst), .bus(f0));
  sync_fifo_v2 #(.DATA_W(DW), .DEPTH(DP), .UPP_TH(UT), .LOW_TH(LT), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst), .bus(f1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    f0.i_wren = 0; f0.i_wrdata = '0; f0.i_rden = 0;
    f1.i_wren = 0; f1.i_wrdata = '0; f1.i_rden = 0;
`ifdef SYNC_FIFO_V2_ERR_EN
    f0.i_clr_err = 0; f1.i_clr_err = 0;
`endif
    #2;
    // Reset state
    chk("rst_count", 32'(f0.o_count), 0);
    chk("rst_empty", 32'(f0.o_empty), 1);
    chk("rst_aempty", 32'(f0.o_alm_empty), 1);
    chk("rst_full", 32'(f0.o_full), 0);
    chk("rst_afull", 32'(f0.o_alm_full), 0);
    chk("rst_rdvalid", 32'(f0.o_rdvalid), 0);
    chk("rst_rddata", 32'(f0.o_rddata), 0);
    chk("rst_fwft_rdvalid", 32'(f1.o_rdvalid), 0);
`ifdef SYNC_FIFO_V2_ERR_EN
    chk("rst_ovf", 32'(f0.o_overflow), 0);
    chk("rst_udf", 32'(f0.o_underflow), 0);
`endif
    tick();
    tick();
    rst = 0;

    // Fill 1..6, flags follow the count
    for (int k = 1; k <= 6; k++) begin
      f0.i_wren = 1; f0.i_wrdata = 16'(k);
      tick();
      chk($sformatf("fill_count%0d", k), 32'(f0.o_count), 32'(k));
      chk($sformatf("fill_full%0d", k), 32'(f0.o_full), 32'(k == 6));
      chk($sformatf("fill_afull%0d", k), 32'(f0.o_alm_full), 32'(k >= 4));
      chk($sformatf("fill_aempty%0d", k), 32'(f0.o_alm_empty), 32'(k <= 1));
    end

    // Full: write dropped, read still completes
    f0.i_wrdata = 16'hBEEF; f0.i_rden = 1;
    tick();
    chk("full_rw_rdvalid", 32'(f0.o_rdvalid), 1);
    chk("full_rw_rddata", 32'(f0.o_rddata), 32'h0001);
    chk("full_rw_count", 32'(f0.o_count), 5);
`ifdef SYNC_FIFO_V2_ERR_EN
    chk("full_rw_ovf", 32'(f0.o_overflow), 1);
    f0.i_clr_err = 1;
`endif
    f0.i_wren = 0;
    tick();
    chk("drain_rddata2", 32'(f0.o_rddata), 32'h0002);
`ifdef SYNC_FIFO_V2_ERR_EN
    chk("clr_ovf", 32'(f0.o_overflow), 0);
    f0.i_clr_err = 0;
`endif
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk($sformatf("drain_rddata%0d", k), 32'(f0.o_rddata), 32'(k));
      chk($sformatf("drain_rdvalid%0d", k), 32'(f0.o_rdvalid), 1);
    end
    f0.i_rden = 0;
    tick();
    chk("drain_end_rdvalid", 32'(f0.o_rdvalid), 0);
    chk("drain_end_hold", 32'(f0.o_rddata), 32'h0006);
    chk("drain_end_empty", 32'(f0.o_empty), 1);

    // Fill 3, read 3 back-to-back
    for (int k = 1; k <= 3; k++) begin
      f0.i_wren = 1; f0.i_wrdata = 16'(k);
      tick();
    end
    f0.i_wren = 0;
    chk("b2b_pre_rdvalid", 32'(f0.o_rdvalid), 0);
    chk("b2b_pre_count", 32'(f0.o_count), 3);
    f0.i_rden = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("b2b_rdvalid%0d", k), 32'(f0.o_rdvalid), 1);
      chk($sformatf("b2b_rddata%0d", k), 32'(f0.o_rddata), 32'(k));
    end
    f0.i_rden = 0;
    tick();
    chk("b2b_post_rdvalid", 32'(f0.o_rdvalid), 0);

    // Stream 20 words with 2 in flight; pointers wrap several times
    for (int c = 0; c < 22; c++) begin
      f0.i_wren = (c < 20); f0.i_wrdata = 16'(16'h0100 + c);
      f0.i_rden = (c >= 2);
      tick();
      if (c >= 2) chk($sformatf("stream_data%0d", c), 32'(f0.o_rddata), 32'(16'h0100 + c - 2));
      chk($sformatf("stream_count%0d", c), 32'(f0.o_count),
          32'((c < 2) ? c + 1 : (c < 20) ? 2 : 21 - c));
    end
    f0.i_wren = 0; f0.i_rden = 0;
    tick();

    // Fill 4, then asynchronous reset between clock edges
    for (int k = 0; k < 4; k++) begin
      f0.i_wren = 1; f0.i_wrdata = 16'(16'h0010 + k);
      tick();
    end
    f0.i_wren = 0;
    chk("pre_arst_count", 32'(f0.o_count), 4);
    #3 rst = 1;
    #1;
    chk("arst_count", 32'(f0.o_count), 0);
    chk("arst_empty", 32'(f0.o_empty), 1);
    chk("arst_aempty", 32'(f0.o_alm_empty), 1);
    #1 rst = 0;
    tick();
    f0.i_rden = 1;
    tick();
    chk("udf_rdvalid", 32'(f0.o_rdvalid), 0);
    chk("udf_count", 32'(f0.o_count), 0);
`ifdef SYNC_FIFO_V2_ERR_EN
    chk("udf_set", 32'(f0.o_underflow), 1);
    f0.i_clr_err = 1;
`endif
    f0.i_rden = 0;
    tick();
`ifdef SYNC_FIFO_V2_ERR_EN
    chk("udf_clr", 32'(f0.o_underflow), 0);
    f0.i_clr_err = 0;
`endif
    // Old words gone: the next word written is the next word read
    f0.i_wren = 1; f0.i_wrdata = 16'h0077;
    tick();
    f0.i_wren = 0; f0.i_rden = 1;
    tick();
    f0.i_rden = 0;
    chk("post_rst_data", 32'(f0.o_rddata), 32'h0077);
    chk("post_rst_count", 32'(f0.o_count), 0);

    // FWFT instance
    chk("fwft_empty_rdvalid", 32'(f1.o_rdvalid), 0);
    f1.i_wren = 1; f1.i_wrdata = 16'h00AA;
    tick();
    chk("fwft_aa_rdvalid", 32'(f1.o_rdvalid), 1);
    chk("fwft_aa_rddata", 32'(f1.o_rddata), 32'h00AA);
    f1.i_wrdata = 16'h00BB; f1.i_rden = 1;
    tick();
    chk("fwft_bb_count", 32'(f1.o_count), 1);
    chk("fwft_bb_rddata", 32'(f1.o_rddata), 32'h00BB);
    chk("fwft_bb_rdvalid", 32'(f1.o_rdvalid), 1);
    f1.i_wren = 0;
    tick();
    chk("fwft_drain_rdvalid", 32'(f1.o_rdvalid), 0);
    f1.i_rden = 0;
    for (int k = 1; k <= 3; k++) begin
      f1.i_wren = 1; f1.i_wrdata = 16'(16'h0030 + k);
      tick();
    end
    f1.i_wren = 0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("fwft_head%0d", k), 32'(f1.o_rddata), 32'(16'h0030 + k));
      f1.i_rden = 1;
      tick();
      f1.i_rden = 0;
    end
    chk("fwft_end_rdvalid", 32'(f1.o_rdvalid), 0);
    chk("fwft_end_empty", 32'(f1.o_empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
